// File: rtl/uart_rx_cfg.sv
// UART receiver: 2-flop RX synchroniser, mid-bit sampling FSM, rdy/frm_err/overrun flags.
// Define UART_RX_PARITY_EN to add a parity bit period and the par_err output.
module uart_rx_cfg #(
    parameter int CLK_DIV    = 2604,
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 frm_err,
    output logic                 overrun
`ifdef UART_RX_PARITY_EN
   ,output logic                 par_err
`endif
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 fall, tick, done;

    assign fall = rx_prev & ~rx_sync;
    assign tick = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:   if (fall) state_nxt = START;
            START:  if (tick) state_nxt = rx_sync ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (tick && bit_cnt == LAST) state_nxt = PARITY;
            PARITY: if (tick) state_nxt = STOP;
`else
            DATA:   if (tick && bit_cnt == LAST) state_nxt = STOP;
`endif
            STOP: begin
                if (tick) begin
                    done      = 1'b1;
                    state_nxt = rx_sync ? IDLE : BRK;
                end
            end
            BRK:    if (rx_sync) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // The edge-detect cycle already counts as the first half-bit cycle.
        if (state_nxt == IDLE || state_nxt == BRK) cnt_nxt = HALF;
        else if (state == IDLE)                    cnt_nxt = HALF - CW'(1);
        else if (tick)                             cnt_nxt = FULL;
        else                                       cnt_nxt = cnt - CW'(1);
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    par_bit <= 1'b0;
        else if (state == PARITY && tick) par_bit <= rx_sync;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= HALF;
            bit_cnt <= '0;
            shreg   <= '0;
            rx_data <= '0;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
            overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            cnt <= cnt_nxt;
            if (state == IDLE && fall) bit_cnt <= '0;
            if (state == DATA && tick) begin
                shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + BW'(1);
            end
            // Completion wins over a same-cycle acknowledge.
            if (done) begin
                rx_data <= shreg;
                rdy     <= 1'b1;
                frm_err <= ~rx_sync;
                overrun <= rdy & ~clr_rdy;
`ifdef UART_RX_PARITY_EN
                par_err <= (^shreg ^ par_bit) != PARITY_ODD;
`endif
            end else if (clr_rdy) begin
                rdy     <= 1'b0;
                frm_err <= 1'b0;
                overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
                par_err <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames are pushed to a scoreboard when sent and
// popped and compared once the frame is delivered.
module tb_uart_rx_cfg;
    localparam int CLK_DIV = 16;
    localparam int DBITS   = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB_TOT = 1 + DBITS + PB + 1;
    // 2 sync flops + half bit + whole bits up to stop mid-bit + 1 registered flag
    localparam int CMP_K  = 2 + CLK_DIV / 2 + CLK_DIV * (DBITS + PB + 1) + 1;

    typedef struct packed {
        logic [7:0] data;
        logic       frm;
        logic       ovr;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, RX, clr_rdy;
    logic [7:0] rx_data;
    logic       rdy, frm_err, overrun;
`ifdef UART_RX_PARITY_EN
    logic       par_err;
`endif

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic model_rdy = 1'b0;

    uart_rx_cfg #(.CLK_DIV(CLK_DIV), .DATA_BITS(DBITS), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rdy(clr_rdy),
        .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .overrun(overrun)
`ifdef UART_RX_PARITY_EN
       ,.par_err(par_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one frame; clr_rdy pulses for the cycle numbered clr_at (edges since the fall).
    task automatic send(input logic [7:0] d, input logic stop, input logic pflip,
                        input int clr_at, input int stop_len, input string tag);
        logic [10:0] line;
        exp_t        e;
        int          k, rdy_k, len;
        logic        was_rdy;
        line = '0;
        line[8:1] = d;
        if (PB == 1) line[9] = ^d ^ pflip;
        line[NB_TOT-1] = stop;
        e.data = d;
        e.frm  = ~stop;
        e.ovr  = model_rdy && (clr_at != CMP_K - 1);
        e.par  = pflip;
        sb.push_back(e);
        was_rdy = rdy;
        rdy_k = -1;
        k = 0;
        for (int b = 0; b < NB_TOT; b++) begin
            RX  = line[b];
            len = (b == NB_TOT - 1) ? stop_len : CLK_DIV;
            for (int c = 0; c < len; c++) begin
                @(posedge clk);
                #1;
                k++;
                clr_rdy = (k == clr_at);
                if (rdy && rdy_k < 0) rdy_k = k;
            end
        end
        clr_rdy   = 1'b0;
        model_rdy = 1'b1;
        if (!was_rdy)
            chk({tag, " latency"}, 32'(rdy_k > CMP_K - CLK_DIV && rdy_k <= CMP_K), 1);
    endtask

    task automatic chk_frame(input string tag);
        exp_t e;
        chk({tag, " sb"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, " rdy"}, 32'(rdy), 1);
            chk({tag, " data"}, 32'(rx_data), 32'(e.data));
            chk({tag, " frm"}, 32'(frm_err), 32'(e.frm));
            chk({tag, " ovr"}, 32'(overrun), 32'(e.ovr));
`ifdef UART_RX_PARITY_EN
            chk({tag, " par"}, 32'(par_err), 32'(e.par));
`endif
        end
    endtask

    task automatic clr();
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy   = 1'b0;
        model_rdy = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; RX = 1'b1; clr_rdy = 1'b0;
        tick(3);
        chk("rst rdy", 32'(rdy), 0);
        chk("rst data", 32'(rx_data), 0);
        chk("rst frm", 32'(frm_err), 0);
        chk("rst ovr", 32'(overrun), 0);
        rst_n = 1'b1;
        tick(5);

        send(8'hA5, 1'b1, 1'b0, -1, CLK_DIV, "a5");
        chk_frame("a5");
        clr();
        chk("a5 clr rdy", 32'(rdy), 0);

        RX = 1'b0; tick(4); RX = 1'b1; tick(40);
        chk("glitch rdy", 32'(rdy), 0);
        send(8'h3C, 1'b1, 1'b0, -1, CLK_DIV, "3c");
        chk_frame("3c");
        clr();

        send(8'h00, 1'b0, 1'b0, -1, CLK_DIV + 40, "brk");
        chk_frame("brk");
        clr();
        chk("brk clr rdy", 32'(rdy), 0);
        chk("brk clr frm", 32'(frm_err), 0);
        tick(150);
        chk("brk hold rdy", 32'(rdy), 0);
        RX = 1'b1; tick(40);
        chk("brk exit rdy", 32'(rdy), 0);
        send(8'h5A, 1'b1, 1'b0, -1, CLK_DIV, "5a");
        chk_frame("5a");
        clr();

        send(8'h11, 1'b1, 1'b0, -1, CLK_DIV, "b2b1");
        chk_frame("b2b1");
        send(8'h22, 1'b1, 1'b0, -1, CLK_DIV, "b2b2");
        chk_frame("b2b2");
        clr();
        chk("ovr clr rdy", 32'(rdy), 0);
        chk("ovr clr ovr", 32'(overrun), 0);

        send(8'h33, 1'b1, 1'b0, -1, CLK_DIV, "33");
        chk_frame("33");
        send(8'h44, 1'b1, 1'b0, CMP_K - 1, CLK_DIV, "clr same");
        chk_frame("clr same");

`ifdef UART_RX_PARITY_EN
        clr();
        send(8'h07, 1'b1, 1'b1, -1, CLK_DIV, "par bad");
        chk_frame("par bad");
        clr();
        send(8'h07, 1'b1, 1'b0, -1, CLK_DIV, "par ok");
        chk_frame("par ok");
`endif

        // Abort a frame of all ones so the line stays high after reset release.
        RX = 1'b0; tick(CLK_DIV);
        RX = 1'b1; tick(30);
        rst_n = 1'b0;
        #2;
        chk("abort rdy", 32'(rdy), 0);
        chk("abort data", 32'(rx_data), 0);
        chk("abort frm", 32'(frm_err), 0);
        chk("abort ovr", 32'(overrun), 0);
`ifdef UART_RX_PARITY_EN
        chk("abort par", 32'(par_err), 0);
`endif
        tick(3);
        rst_n = 1'b1;
        model_rdy = 1'b0;
        tick(250);
        chk("abort no rdy", 32'(rdy), 0);
        send(8'h96, 1'b1, 1'b0, -1, CLK_DIV, "96");
        chk_frame("96");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
